pc_fetch_ctrl: RTL and testbench

Program-counter register and fetch sequencer for the MIPS IF stage. It consumes the incremented PC and the redirect targets from the later stages, and drives the instruction-memory address. It also gates fetches according to run, single-step and halt control from the debug unit. Addressing is word-based: sequential next PC is PC+1.

---
 rtl/pc_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencer for the IF stage.
// Holds the word-addressed PC, picks the next PC from the redirect/stall
// inputs, and gates fetches with the debug run/step/halt sequencer.
module pc_fetch_ctrl #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              IMEM_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0]    HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  input  logic [DATA_WIDTH-1:0] i_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_incr,
  output logic                  o_fetch_valid,
  output logic                  o_halted,
  output logic [1:0]            o_state,
  output logic [DATA_WIDTH-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(IMEM_DEPTH);

  state_e                state_q,  state_d;
  logic [DATA_WIDTH-1:0] pc_q,     pc_d;
  logic [DATA_WIDTH-1:0] cycle_q,  cycle_d;
  logic                  halted_q, halted_d;

  logic                  active;
  logic                  in_range;
  logic                  redirect;
  logic                  halt_hit;
  logic [DATA_WIDTH-1:0] pc_incr;
  logic [DATA_WIDTH-1:0] pc_sel;

  // Fetch qualification and next-PC priority (branch > jump > stall > increment)
  always_comb begin
    pc_incr  = pc_q + 1'b1;
    active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    in_range = (pc_q < DEPTH_W);
    redirect = i_branch_taken || i_jump;
    o_fetch_valid = active && !i_stall && in_range;
    halt_hit = o_fetch_valid && (i_instr == HALT_INSTR) && !redirect;
    if (i_branch_taken) begin
      pc_sel = i_branch_target;
    end else if (i_jump) begin
      pc_sel = i_jump_target;
    end else if (i_stall) begin
      pc_sel = pc_q;
    end else begin
      pc_sel = pc_incr;
    end
  end

  // Sequencer next state, PC update and RUN/STEP cycle counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cycle_d = cycle_q;
    if (active && (cycle_q != '1)) begin
      cycle_d = cycle_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_hit || !in_range) begin
          state_d = ST_HALTED;
        end else begin
          pc_d = pc_sel;
        end
      end
      ST_STEP: begin
        // A stalled step waits in STEP; the first fetch or redirect completes it.
        if (halt_hit || !in_range) begin
          state_d = ST_HALTED;
        end else if (redirect || o_fetch_valid) begin
          pc_d    = pc_sel;
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (i_reset) begin
      state_d = ST_IDLE;
      pc_d    = '0;
      cycle_d = '0;
    end
    halted_d = (state_d == ST_HALTED);
  end

  // State registers
  always_ff @(posedge i_clock) begin
    state_q  <= state_d;
    pc_q     <= pc_d;
    cycle_q  <= cycle_d;
    halted_q <= halted_d;
  end

  assign o_pc          = pc_q;
  assign o_pc_incr     = pc_incr;
  assign o_halted      = halted_q;
  assign o_state       = state_q;
  assign o_cycle_count = cycle_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios followed by random stimulus, each
// cycle compared against a behavioural model of the fetch sequencer.
module tb_pc_fetch_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst, start, step, stall, br, jmp;
  logic [DW-1:0] br_tgt, jmp_tgt, instr;
  logic [DW-1:0] pc, pc_incr, cyc;
  logic          fv, halted;
  logic [1:0]    state;

  logic [31:0]   imem [DEPTH];

  int            checks = 0;
  int            errors = 0;

  // model state: mode 0=idle 1=run 2=step 3=halted
  logic [31:0]   m_pc;
  int            m_mode;
  logic [31:0]   m_cyc;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .DATA_WIDTH(DW),
    .IMEM_DEPTH(DEPTH),
    .HALT_INSTR(HALT)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_step         (step),
    .i_stall        (stall),
    .i_branch_taken (br),
    .i_branch_target(br_tgt),
    .i_jump         (jmp),
    .i_jump_target  (jmp_tgt),
    .i_instr        (instr),
    .o_pc           (pc),
    .o_pc_incr      (pc_incr),
    .o_fetch_valid  (fv),
    .o_halted       (halted),
    .o_state        (state),
    .o_cycle_count  (cyc)
  );

  always_comb begin
    instr = 32'hDEAD_BEEF;
    if (pc < DEPTH) instr = imem[pc[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_fetch_word(input logic [31:0] a);
    if (a < DEPTH) return imem[a[5:0]];
    return 32'hDEAD_BEEF;
  endfunction

  // Called just after a rising edge: drive inputs, compare outputs with the
  // model, then advance the model across the next rising edge.
  task automatic do_cycle(input logic r, input logic s, input logic sp, input logic stl,
                          input logic b, input logic [31:0] bt,
                          input logic j, input logic [31:0] jt);
    logic        busy, fetch, redir, halt_now;
    logic [31:0] tgt, n_pc, n_cyc;
    int          n_mode;
    rst = r; start = s; step = sp; stall = stl;
    br = b; br_tgt = bt; jmp = j; jmp_tgt = jt;
    #2;
    busy  = (m_mode == 1) || (m_mode == 2);
    fetch = busy && !stl && (m_pc < DEPTH);
    redir = b || j;
    tgt   = b ? bt : jt;
    halt_now = fetch && !redir && (m_fetch_word(m_pc) == HALT);
    check("pc", pc, m_pc);
    check("pc_incr", pc_incr, m_pc + 32'd1);
    check("fetch_valid", {31'd0, fv}, {31'd0, fetch});
    check("state", {30'd0, state}, 32'(m_mode));
    check("halted", {31'd0, halted}, {31'd0, m_mode == 3});
    check("cycle_count", cyc, m_cyc);
    n_pc = m_pc; n_mode = m_mode; n_cyc = m_cyc;
    if (busy && m_cyc != 32'hFFFF_FFFF) n_cyc = m_cyc + 1;
    if (m_mode == 0) begin
      if (s) n_mode = 1;
      else if (sp) n_mode = 2;
    end else if (busy) begin
      if (halt_now || m_pc >= DEPTH) n_mode = 3;
      else if (redir) begin
        n_pc = tgt;
        if (m_mode == 2) n_mode = 0;
      end else if (!stl) begin
        n_pc = m_pc + 1;
        if (m_mode == 2) n_mode = 0;
      end
    end
    if (r) begin
      n_pc = 0; n_mode = 0; n_cyc = 0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_mode = n_mode; m_cyc = n_cyc;
  endtask

  task automatic idle_cycle(input logic stl);
    do_cycle(1'b0, 1'b0, 1'b0, stl, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; stall = 1'b0;
    br = 1'b0; jmp = 1'b0; br_tgt = '0; jmp_tgt = '0;
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = 32'd0;
    m_pc = 32'hFFFF_FFFF; m_mode = 0; m_cyc = 0;
    @(posedge clk);
    #1;
    m_pc = 0; m_mode = 0; m_cyc = 0;

    // reset state, then idle with stall toggling
    do_reset();
    check("rst_pc_incr", pc_incr, 32'd1);
    for (int i = 0; i < 5; i++) idle_cycle(1'(i % 2));
    check("idle_pc", pc, 32'd0);

    // continuous run over NOPs
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) idle_cycle(1'b0);
    check("run_cycles", cyc, 32'd5);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    check("stall_hold", pc, 32'd7);
    idle_cycle(1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'd0);
    check("redirect_over_stall", pc, 32'h20);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40);
    check("branch_over_jump", pc, 32'h10);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h40);
    check("jump", pc, 32'h40);
    idle_cycle(1'b0);
    check("oob_halt", {30'd0, state}, 32'd3);
    idle_cycle(1'b0);

    // halt instruction at address 5
    do_reset();
    imem[5] = HALT;
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) idle_cycle(1'b0);
    for (int i = 0; i < 10; i++)
      do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("halt_pc", pc, 32'd5);
    do_reset();
    check("halt_rst_state", {30'd0, state}, 32'd0);
    imem[5] = 32'd0;

    // single steps, including a stalled step and a redirected step
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      idle_cycle(1'b0);
    end
    check("step_pc", pc, 32'd4);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    check("stalled_step_pc", pc, 32'd5);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd62);
    check("step_jump_pc", pc, 32'd62);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) idle_cycle(1'b0);
    check("end_of_mem_halt", {31'd0, halted}, 32'd1);

    // random phase
    for (int i = 0; i < int'(DEPTH); i++)
      imem[i] = ($urandom_range(0, 39) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0) || (m_mode == 3 && $urandom_range(0, 7) == 0);
      do_cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0, 32'($urandom_range(0, 70)),
               $urandom_range(0, 9) == 0, 32'($urandom_range(0, 70)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
